// File: rtl/dffn_setrst_pipe_if.sv
// dffn_setrst_pipe_if
//   Groups the data, control and status signals of dffn_setrst_pipe.
//   Clock and reset stay as plain ports on the design.
//   Signals:
//     EN   load enable
//     SE   scan enable
//     SI   scan serial input
//     D    parallel data into stage 0 (WIDTH bits)
//     Q    last stage contents (WIDTH bits)
//     SO   scan serial output
//     VLD  pipe holds DEPTH consecutive loaded words
//     FILL loads since last reset/scan, saturating at DEPTH
//   Modports:
//     master drives the controls and data, observes the status.
//     slave  is the pipeline side.
interface dffn_setrst_pipe_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned FW = $clog2(DEPTH + 1);

    logic             EN;
    logic             SE;
    logic             SI;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             SO;
    logic             VLD;
    logic [FW-1:0]    FILL;

    modport master (
        output EN, SE, SI, D,
        input  Q, SO, VLD, FILL
    );

    modport slave (
        input  EN, SE, SI, D,
        output Q, SO, VLD, FILL
    );
endinterface

// File: rtl/dffn_setrst_pipe.sv
// dffn_setrst_pipe
//   Negative-edge register pipeline of DEPTH stages, WIDTH bits each.
//   Async active-high reset loads INIT into every stage. Loading shifts D into
//   stage 0 and advances the pipe. Scan mode threads all stages into one
//   serial chain. FILL counts loads since reset/scan (saturating at DEPTH),
//   and VLD flags a full pipe.
//   Ports:
//     CLKN  clock, all state updates on its falling edge
//     RST   asynchronous reset, active-high
//     bus   dffn_setrst_pipe_if.slave (EN, SE, SI, D in; Q, SO, VLD, FILL out)
//   Priority per falling edge: RST > SE > EN > hold.
module dffn_setrst_pipe #(
    parameter int unsigned      WIDTH = 8,
    parameter int unsigned      DEPTH = 2,
    parameter logic [WIDTH-1:0] INIT  = '1
) (
    input logic               CLKN,
    input logic               RST,
    dffn_setrst_pipe_if.slave bus
);
    localparam int unsigned   NBITS = WIDTH * DEPTH;
    localparam int unsigned   FW    = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] FULL  = FW'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
    logic [FW-1:0]               fill_q, fill_d;
    logic                        vld_q, vld_d;
    logic [NBITS:0]              chain_ext;

    always_comb begin
        stage_d   = stage_q;
        fill_d    = fill_q;
        // Flat bit k*WIDTH+b is stage k bit b, so one left shift with SI at
        // bit 0 walks the chain SI -> stage0[0] ... -> stage(DEPTH-1)[WIDTH-1].
        chain_ext = {stage_q, bus.SI};
        if (bus.SE) begin
            stage_d = chain_ext[NBITS-1:0];
            fill_d  = '0;
        end else if (bus.EN) begin
            stage_d[0] = bus.D;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            if (fill_q != FULL) begin
                fill_d = fill_q + FW'(1);
            end
        end
        vld_d = (fill_d == FULL);
    end

    always_ff @(negedge CLKN or posedge RST) begin
        if (RST) begin
            stage_q <= {DEPTH{INIT}};
            fill_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            stage_q <= stage_d;
            fill_q  <= fill_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.Q    = stage_q[DEPTH-1];
    assign bus.SO   = stage_q[DEPTH-1][WIDTH-1];
    assign bus.VLD  = vld_q;
    assign bus.FILL = fill_q;
endmodule

// File: tb/tb_dffn_setrst_pipe.sv
// Bench for dffn_setrst_pipe: a WIDTH=8/DEPTH=2/INIT=A5 instance and a
// WIDTH=8/DEPTH=1/INIT=00 instance on a shared falling-edge clock.
module tb_dffn_setrst_pipe;

    logic clkn = 1'b1;
    always #5 clkn = ~clkn;

    logic rst0;
    logic rst1;

    dffn_setrst_pipe_if #(.WIDTH(8), .DEPTH(2)) bus0 ();
    dffn_setrst_pipe_if #(.WIDTH(8), .DEPTH(1)) bus1 ();

    dffn_setrst_pipe #(.WIDTH(8), .DEPTH(2), .INIT(8'hA5)) dut0 (
        .CLKN (clkn),
        .RST  (rst0),
        .bus  (bus0.slave)
    );

    dffn_setrst_pipe #(.WIDTH(8), .DEPTH(1), .INIT(8'h00)) dut1 (
        .CLKN (clkn),
        .RST  (rst1),
        .bus  (bus1.slave)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model of the DEPTH=2 instance: a list of two words plus a
    // load counter; scan treats the two words as one 16-bit number.
    logic [7:0] m_st [2];
    int         m_fill;

    task automatic model_reset();
        m_st[0] = 8'hA5;
        m_st[1] = 8'hA5;
        m_fill  = 0;
    endtask

    task automatic model_step(input logic en, input logic se, input logic si, input logic [7:0] d);
        int chain;
        if (se) begin
            chain   = (int'(m_st[1]) * 256) + int'(m_st[0]);
            chain   = ((chain * 2) + int'(si)) % 65536;
            m_st[1] = 8'(chain / 256);
            m_st[0] = 8'(chain % 256);
            m_fill  = 0;
        end else if (en) begin
            m_st[1] = m_st[0];
            m_st[0] = d;
            if (m_fill < 2) m_fill++;
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] mq;
        mq = m_st[1];
        check({tag, "_q"},    32'(bus0.Q),    32'(mq));
        check({tag, "_so"},   32'(bus0.SO),   32'(mq[7]));
        check({tag, "_vld"},  32'(bus0.VLD),  32'(m_fill == 2));
        check({tag, "_fill"}, 32'(bus0.FILL), 32'(m_fill));
    endtask

    // Drive inputs just after a falling edge, wait for the next one, sample
    // 1 time unit later, and advance the model.
    task automatic step0(input logic en, input logic se, input logic si, input logic [7:0] d);
        bus0.EN = en;
        bus0.SE = se;
        bus0.SI = si;
        bus0.D  = d;
        @(negedge clkn);
        #1;
        model_step(en, se, si, d);
    endtask

    task automatic pulse_rst0(input string tag);
        rst0 = 1'b1;
        #1;
        model_reset();
        check({tag, "_q"},    32'(bus0.Q),    32'h0000_00A5);
        check({tag, "_so"},   32'(bus0.SO),   32'd1);
        check({tag, "_vld"},  32'(bus0.VLD),  32'd0);
        check({tag, "_fill"}, 32'(bus0.FILL), 32'd0);
        rst0 = 1'b0;
        #1;
    endtask

    typedef struct {
        logic       en;
        logic [7:0] d;
        logic [7:0] exp_q;
        logic       exp_so;
        logic       exp_vld;
        logic [1:0] exp_fill;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [15:0] scan_word;
        logic [15:0] prior;
        logic        b;

        // Fill then hold: latency of two loads, FILL saturates at 2.
        vecs[0] = '{1'b1, 8'h01, 8'hA5, 1'b1, 1'b0, 2'd1};
        vecs[1] = '{1'b1, 8'h02, 8'h01, 1'b0, 1'b1, 2'd2};
        vecs[2] = '{1'b1, 8'h03, 8'h02, 1'b0, 1'b1, 2'd2};
        vecs[3] = '{1'b0, 8'hFF, 8'h02, 1'b0, 1'b1, 2'd2};
        vecs[4] = '{1'b0, 8'h00, 8'h02, 1'b0, 1'b1, 2'd2};
        vecs[5] = '{1'b0, 8'hAA, 8'h02, 1'b0, 1'b1, 2'd2};
        vecs[6] = '{1'b0, 8'h55, 8'h02, 1'b0, 1'b1, 2'd2};
        vecs[7] = '{1'b0, 8'hFF, 8'h02, 1'b0, 1'b1, 2'd2};

        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.EN = 1'b0; bus0.SE = 1'b0; bus0.SI = 1'b0; bus0.D = 8'h00;
        bus1.EN = 1'b0; bus1.SE = 1'b0; bus1.SI = 1'b0; bus1.D = 8'h00;
        model_reset();
        #2;
        check_model("por");
        @(negedge clkn);
        #1;
        check_model("por_edge");
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Reset pulse between edges after some loads.
        step0(1'b1, 1'b0, 1'b0, 8'h77);
        step0(1'b1, 1'b0, 1'b0, 8'h88);
        check_model("preload");
        pulse_rst0("rst_pulse");

        // Table-driven fill/latency and hold.
        foreach (vecs[i]) begin
            step0(vecs[i].en, 1'b0, 1'b0, vecs[i].d);
            check($sformatf("vec%0d_q", i),    32'(bus0.Q),    32'(vecs[i].exp_q));
            check($sformatf("vec%0d_so", i),   32'(bus0.SO),   32'(vecs[i].exp_so));
            check($sformatf("vec%0d_vld", i),  32'(bus0.VLD),  32'(vecs[i].exp_vld));
            check($sformatf("vec%0d_fill", i), 32'(bus0.FILL), 32'(vecs[i].exp_fill));
        end

        // Scan 16'hBEEF in so that stage0=EF and stage1=BE; SO replays the
        // previous chain {stage1, stage0} = 16'h0203 from the top bit down.
        scan_word = 16'hBEEF;
        prior     = 16'h0203;
        for (int j = 0; j < 16; j++) begin
            b = scan_word[15-j];
            step0(1'b0, 1'b1, b, 8'h5A);
            if (j == 0) check("scan_vld_first", 32'(bus0.VLD), 32'd0);
            if (j < 15) check($sformatf("scan_so%0d", j), 32'(bus0.SO), 32'(prior[14-j]));
            check_model($sformatf("scan%0d", j));
        end
        check("scan_stage1", 32'(bus0.Q), 32'h0000_00BE);
        for (int j = 0; j < 8; j++) step0(1'b0, 1'b1, 1'b0, 8'h00);
        check("scan_stage0", 32'(bus0.Q), 32'h0000_00EF);

        // SE and EN together: one bit shift, D ignored.
        step0(1'b1, 1'b1, 1'b1, 8'hFF);
        check_model("se_en");
        // Reset in the middle of a scan.
        bus0.SE = 1'b1;
        pulse_rst0("rst_scan");
        bus0.SE = 1'b0;

        // Randomized stimulus against the model, with occasional resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                pulse_rst0($sformatf("rnd_rst%0d", i));
            end else begin
                step0(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                      1'($urandom_range(0, 1)), 8'($urandom));
                check_model($sformatf("rnd%0d", i));
            end
        end

        // DEPTH=1, INIT=0 instance.
        rst1 = 1'b1;
        #1;
        check("d1_rst_q",    32'(bus1.Q),    32'd0);
        check("d1_rst_vld",  32'(bus1.VLD),  32'd0);
        check("d1_rst_fill", 32'(bus1.FILL), 32'd0);
        rst1 = 1'b0;
        bus1.EN = 1'b1;
        bus1.D  = 8'h3C;
        @(negedge clkn);
        #1;
        check("d1_load_q",    32'(bus1.Q),    32'h0000_003C);
        check("d1_load_vld",  32'(bus1.VLD),  32'd1);
        check("d1_load_fill", 32'(bus1.FILL), 32'd1);
        bus1.D = 8'h55;
        @(posedge clkn);
        #1;
        check("d1_posedge_q",   32'(bus1.Q),    32'h0000_003C);
        check("d1_posedge_vld", 32'(bus1.VLD),  32'd1);
        @(negedge clkn);
        #1;
        check("d1_load2_q",    32'(bus1.Q),    32'h0000_0055);
        check("d1_load2_fill", 32'(bus1.FILL), 32'd1);
        bus1.EN = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
